// File: rtl/hilo_register.sv
// HI/LO result register for the shift-add MULTU datapath.
// Counts multiplier iterations while MULTU is held, captures the 64-bit
// product into HI/LO on the edge after the last iteration, and serves
// MFHI/MFLO reads with a stall while a product is still in flight.
//
// Handshake: a read (MFHI/MFLO on Signal) is accepted in any cycle where
// stall is low; while stall is high the consumer must hold the read and
// dataOut is forced to zero.
module hilo_register #(
   parameter int          WIDTH = 32,
   parameter int          ITER  = 32,
   parameter logic [5:0]  MULTU = 6'b011001,
   parameter logic [5:0]  MFHI  = 6'b010000,
   parameter logic [5:0]  MFLO  = 6'b010010
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [5:0]           Signal,
   input  logic [2*WIDTH-1:0]   dataIn,
   output logic [WIDTH-1:0]     dataOut,
   output logic                 busy,
   output logic                 stall,
   output logic                 done,
   output logic [1:0]           dbg_state_o,
   output logic [5:0]           dbg_cnt_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COUNT   = 2'd1,
      CAPTURE = 2'd2,
      HOLD    = 2'd3
   } state_t;

   localparam logic [5:0] ITER_C = 6'(ITER);

   state_t            state_q, state_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]  hi_q, lo_q;
   logic              done_q;
   logic              capture;
   logic              is_multu;
   logic              is_read;

   assign is_multu = (Signal == MULTU);
   assign is_read  = (Signal == MFHI) || (Signal == MFLO);

   // State and iteration counter registers; reset aborts any multiply.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: count MULTU edges, capture once, then ignore a held MULTU.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (is_multu) begin
               // The multiplier performs iteration 1 on this same edge.
               state_d = COUNT;
               cnt_d   = 6'd1;
            end
         end
         COUNT: begin
            if (!is_multu) begin
               // Aborted multiply: partial product is discarded.
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               // Saturate at ITER so the counter can never wrap.
               if (cnt_q != ITER_C) begin
                  cnt_d = cnt_q + 6'd1;
               end
               if ((cnt_q + 6'd1 == ITER_C) || (cnt_q == ITER_C)) begin
                  state_d = CAPTURE;
               end
            end
         end
         CAPTURE: begin
            capture = 1'b1;
            cnt_d   = '0;
            state_d = is_multu ? HOLD : IDLE;
         end
         HOLD: begin
            // A MULTU that stays on the bus must not start a second multiply.
            if (!is_multu) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // HI/LO capture and the one-cycle done pulse following the capture edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= capture;
         if (capture) begin
            hi_q <= dataIn[2*WIDTH-1:WIDTH];
            lo_q <= dataIn[WIDTH-1:0];
         end
      end
   end

   // Combinational status and read data; a stalled read returns zero.
   always_comb begin
      busy    = (state_q == COUNT) || (state_q == CAPTURE);
      stall   = is_read && busy;
      dataOut = '0;
      if (!stall) begin
         if (Signal == MFHI) begin
            dataOut = hi_q;
         end else if (Signal == MFLO) begin
            dataOut = lo_q;
         end
      end
   end

   assign done        = done_q;
   assign dbg_state_o = state_q;
   assign dbg_cnt_o   = cnt_q;

endmodule

// File: tb/tb_hilo_register.sv
// Bench for hilo_register: directed vector table, hand-written reset
// sequences, and randomized MULTU/MFHI/MFLO traffic against an edge-count model.
module tb_hilo_register;

   localparam logic [5:0] C_MULTU = 6'b011001;
   localparam logic [5:0] C_MFHI  = 6'b010000;
   localparam logic [5:0] C_MFLO  = 6'b010010;
   localparam logic [5:0] C_NOP   = 6'b000000;
   localparam int         ITER    = 32;

   logic        clk;
   logic        reset;
   logic [5:0]  sig;
   logic [63:0] din;
   logic [31:0] dout;
   logic        busy;
   logic        stall;
   logic        done;
   logic [1:0]  dbg_state;
   logic [5:0]  dbg_cnt;

   int total;
   int bad;

   hilo_register dut (
      .clk         (clk),
      .reset       (reset),
      .Signal      (sig),
      .dataIn      (din),
      .dataOut     (dout),
      .busy        (busy),
      .stall       (stall),
      .done        (done),
      .dbg_state_o (dbg_state),
      .dbg_cnt_o   (dbg_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Directed table: drive sig/din, apply n edges, then compare.
   typedef struct {
      string       name;
      logic [5:0]  sig;
      logic [63:0] din;
      int          n;
      logic        busy;
      logic        stall;
      logic        done;
      logic [31:0] dout;
      logic [5:0]  cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string name, input logic [5:0] s, input logic [63:0] d,
                               input int n, input logic b, input logic st, input logic dn,
                               input logic [31:0] o, input logic [5:0] c);
      vec_t v;
      v.name = name; v.sig = s; v.din = d; v.n = n; v.busy = b;
      v.stall = st; v.done = dn; v.dout = o; v.cnt = c;
      return v;
   endfunction

   // Behavioural model: multiply progress tracked as edges since the run began.
   // 0 = idle, 1..ITER counting, ITER = capture pending, ITER+1 = held after capture.
   int          m_run;
   logic [31:0] m_hi, m_lo;
   logic        m_done;

   function automatic logic m_busy();
      return (m_run >= 1) && (m_run <= ITER);
   endfunction

   task automatic model_edge(input logic [5:0] s, input logic [63:0] d);
      m_done = 1'b0;
      if (m_run == 0) begin
         if (s == C_MULTU) m_run = 1;
      end else if (m_run < ITER) begin
         m_run = (s == C_MULTU) ? m_run + 1 : 0;
      end else if (m_run == ITER) begin
         m_hi = d[63:32];
         m_lo = d[31:0];
         m_done = 1'b1;
         m_run = (s == C_MULTU) ? ITER + 1 : 0;
      end else begin
         m_run = (s == C_MULTU) ? m_run : 0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   logic [63:0] max_p;
   int          done_cnt;

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      sig   = C_NOP;
      din   = '0;
      max_p = 64'hFFFFFFFF * 64'hFFFFFFFF;

      // Async reset between edges takes effect without a clock edge.
      #2 reset = 1'b1;
      #1;
      check("rst_busy", busy, 0);
      check("rst_dout", dout, 0);
      check("rst_done", done, 0);
      check("rst_cnt", dbg_cnt, 0);
      check("rst_state", dbg_state, 0);
      @(negedge clk);
      reset = 1'b0;
      sig = C_MFHI;
      #1;
      check("rst_mfhi", dout, 0);
      sig = C_MFLO;
      #1;
      check("rst_mflo", dout, 0);
      @(posedge clk);
      #1;

      // name, sig, din, edges, busy, stall, done, dout, cnt
      vecs.push_back(mk("max_count",   C_MULTU, max_p, 32, 1, 0, 0, 32'h0, 6'd32));
      vecs.push_back(mk("max_capture", C_MULTU, max_p, 1,  0, 0, 1, 32'h0, 6'd0));
      vecs.push_back(mk("max_mfhi",    C_MFHI,  '0,    1,  0, 0, 0, 32'hFFFFFFFE, 6'd0));
      vecs.push_back(mk("max_mflo",    C_MFLO,  '0,    1,  0, 0, 0, 32'h00000001, 6'd0));
      vecs.push_back(mk("early_cnt",   C_MULTU, 64'd15, 10, 1, 0, 0, 32'h0, 6'd10));
      vecs.push_back(mk("early_stall", C_MFLO,  '0,    0,  1, 1, 0, 32'h0, 6'd10));
      vecs.push_back(mk("early_abort", C_MFLO,  '0,    1,  0, 0, 0, 32'h00000001, 6'd0));
      vecs.push_back(mk("full_3x5",    C_MULTU, 64'd15, 33, 0, 0, 1, 32'h0, 6'd0));
      vecs.push_back(mk("3x5_mflo",    C_MFLO,  '0,    1,  0, 0, 0, 32'h0000000F, 6'd0));
      vecs.push_back(mk("3x5_mfhi",    C_MFHI,  '0,    1,  0, 0, 0, 32'h00000000, 6'd0));
      vecs.push_back(mk("stall_cnt",   C_MULTU, 64'h1234, 19, 1, 0, 0, 32'h0, 6'd19));
      vecs.push_back(mk("stall_mfhi",  C_MFHI,  '0,    0,  1, 1, 0, 32'h0, 6'd19));
      vecs.push_back(mk("stall_abort", C_MFHI,  '0,    1,  0, 0, 0, 32'h0, 6'd0));
      vecs.push_back(mk("held_count",  C_MULTU, 64'h00000001_00000000, 32, 1, 0, 0, 32'h0, 6'd32));
      vecs.push_back(mk("held_cap",    C_MULTU, 64'h00000001_00000000, 1,  0, 0, 1, 32'h0, 6'd0));
      vecs.push_back(mk("held_tail",   C_MULTU, 64'hDEAD_BEEF_0BAD_F00D, 7, 0, 0, 0, 32'h0, 6'd0));
      vecs.push_back(mk("held_mfhi",   C_MFHI,  '0,    1,  0, 0, 0, 32'h00000001, 6'd0));
      vecs.push_back(mk("held_mflo",   C_MFLO,  '0,    1,  0, 0, 0, 32'h00000000, 6'd0));

      foreach (vecs[i]) begin
         sig = vecs[i].sig;
         din = vecs[i].din;
         repeat (vecs[i].n) @(posedge clk);
         #1;
         check({vecs[i].name, ".busy"},  busy,    vecs[i].busy);
         check({vecs[i].name, ".stall"}, stall,   vecs[i].stall);
         check({vecs[i].name, ".done"},  done,    vecs[i].done);
         check({vecs[i].name, ".dout"},  dout,    vecs[i].dout);
         check({vecs[i].name, ".cnt"},   dbg_cnt, vecs[i].cnt);
      end

      // Held MULTU for 40 edges gives exactly one done pulse.
      sig = C_NOP;
      @(posedge clk); #1;
      sig = C_MULTU;
      din = 64'h00000002_00000003;
      done_cnt = 0;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk); #1;
         if (done) done_cnt++;
         if (e >= 33) check("held40_busy", busy, 0);
      end
      check("held40_done_count", done_cnt, 1);

      // Reset asserted mid-multiply (after edge 16) aborts and clears HI/LO.
      sig = C_NOP;
      @(posedge clk); #1;
      sig = C_MULTU;
      din = 64'd99;
      repeat (16) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_cnt", dbg_cnt, 0);
      check("midrst_state", dbg_state, 0);
      @(negedge clk);
      reset = 1'b0;
      sig = C_MFHI;
      #1;
      check("midrst_hi", dout, 0);
      sig = C_MFLO;
      #1;
      check("midrst_lo", dout, 0);
      @(posedge clk); #1;
      sig = C_MULTU;
      din = 64'd42;
      repeat (33) @(posedge clk);
      #1;
      check("7x6_done", done, 1);
      sig = C_MFLO;
      @(posedge clk); #1;
      check("7x6_mflo", dout, 32'h0000002A);

      // Randomized traffic against the edge-count model.
      do_reset();
      m_run = 0; m_hi = '0; m_lo = '0; m_done = 1'b0;
      @(posedge clk); #1;
      for (int r = 0; r < 120; r++) begin
         int          len;
         logic [5:0]  code;
         int          pick;
         pick = $urandom_range(0, 9);
         if (pick < 5) begin
            code = C_MULTU;
            len  = $urandom_range(1, 45);
         end else begin
            code = (pick < 7) ? C_MFHI : (pick < 9) ? C_MFLO : C_NOP;
            len  = $urandom_range(1, 3);
         end
         for (int k = 0; k < len; k++) begin
            logic [31:0] exp_o;
            sig = code;
            din = {$urandom, $urandom};
            #1;
            exp_o = 32'h0;
            if (!m_busy()) begin
               if (sig == C_MFHI) exp_o = m_hi;
               else if (sig == C_MFLO) exp_o = m_lo;
            end
            check("rnd_busy", busy, m_busy());
            check("rnd_stall", stall, ((sig == C_MFHI) || (sig == C_MFLO)) && m_busy());
            check("rnd_dout", dout, exp_o);
            @(posedge clk);
            model_edge(sig, din);
            #1;
            check("rnd_done", done, m_done);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/hilo_register.md
Name: hilo_register

Overview:
- Downstream consumer of the shift-add MULTU datapath; sits between the multiplier and the register-file writeback mux.
- Counts the multiplier's iteration cycles while the function code is MULTU, then captures the final 64-bit product into the HI/LO registers.
- Serves MFHI/MFLO reads and raises a stall when a read arrives before the product is valid.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each, product input is 2*WIDTH.
- ITER, 32, multiplier iterations per MULTU; must equal WIDTH.
- MULTU, 6'b011001, function code that starts/continues a multiply.
- MFHI, 6'b010000, function code that reads HI.
- MFLO, 6'b010010, function code that reads LO.

Ports:
- clk  in  1  rising-edge clock shared with the multiplier.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- Signal  in  6  function code, the same bus that drives the multiplier.
- dataIn  in  64  product from the multiplier's dataOut.
- dataOut  out  32  HI on MFHI, LO on MFLO, otherwise 0.
- busy  out  1  high while a multiply is counting or awaiting capture.
- stall  out  1  high when Signal is MFHI/MFLO and busy is high.
- done  out  1  one-cycle pulse on the edge that writes HI/LO.

Behaviour:
- Reset (async, active-high):
  - HI=0, LO=0, cnt=0, state=IDLE.
  - busy=0, stall=0, done=0, dataOut=0.
  - Asserting reset mid-multiply aborts the operation; HI/LO are forced to 0.
- State machine (IDLE, COUNT, CAPTURE, HOLD):
  - IDLE: on a rising edge with Signal==MULTU, go to COUNT with cnt=1. The multiplier performs iteration 1 on the same edge.
  - COUNT: each edge with Signal==MULTU increments cnt. On the edge where cnt reaches ITER, go to CAPTURE. If Signal!=MULTU on any edge in COUNT, go to IDLE with cnt=0 and leave HI/LO unchanged (aborted multiply is discarded).
  - CAPTURE: on the next edge, HI<=dataIn[63:32] and LO<=dataIn[31:0], done=1 for that cycle. Go to HOLD if Signal==MULTU, else IDLE.
  - HOLD: stay while Signal==MULTU, so one held MULTU cannot re-trigger. Go to IDLE on the first edge with Signal!=MULTU. No capture occurs in HOLD.
- busy is combinational: 1 in COUNT and CAPTURE, 0 in IDLE and HOLD.
- Latency: a MULTU held for ITER+1 edges (first edge = edge 1) updates HI/LO on edge ITER+1 (edge 33). HI/LO are readable in the cycle after edge 33.
- dataOut (combinational from HI/LO/Signal):
  - MFHI gives HI; MFLO gives LO; any other code gives 0.
  - While stall=1, dataOut=0.
- Simultaneous events:
  - MFHI/MFLO cannot coexist with MULTU on a single bus.
  - A read in the same cycle as the capture edge sees the pre-capture HI/LO. It has stall=1 because busy=1 in CAPTURE.
- Arithmetic: unsigned only, no sign extension. The 64-bit dataIn is split exactly, with no truncation or overflow handling.
- cnt is 6 bits wide and saturates at ITER; it never wraps.

Test Plan:
- Reset: assert reset asynchronously between edges → HI=LO=0, busy=0 and dataOut=0 immediately; then MFHI → dataOut=0x00000000.
- Max product: dataA=0xFFFFFFFF, dataB=0xFFFFFFFF, MULTU held 33 edges → done pulses on edge 33; MFHI → 0xFFFFFFFE, MFLO → 0x00000001.
- Early read: issue MULTU (dataA=3, dataB=5) for 10 edges, then MFLO → state aborts to IDLE, LO unchanged from the prior value 0x00000001; repeat with a full 33 edges → MFLO → 0x0000000F, MFHI → 0x00000000.
- Stall: during COUNT, check stall=1 and dataOut=0 for a sampled MFHI/MFLO code (bench forces Signal=MFHI for one cycle at edge 20, which also aborts) → stall=1 in that cycle, cnt returns to 0.
- Held MULTU: keep MULTU for 40 edges with dataA=0x00010000, dataB=0x00010000 → exactly one done pulse (edge 33), HI=0x00000001, LO=0x00000000, busy=0 from edge 33 onward.
- Reset mid-operation: assert reset at edge 16 of a MULTU → HI=LO=0, state IDLE; a fresh MULTU 7×6 completes → LO=0x0000002A.
